if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//   Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, drives
//   the InstructionMemory address, and latches the returned word into the
//   IF/ID pipeline register.
//   Selects the next PC from PC+4, the ID-stage jump target or the EX-stage
//   branch target, and honours stall/flush requests from the hazard unit.
// PARAMETERS
//   RESET_PC   32'h0040_0000  PC value loaded on reset (program entry)
//   NOP_WORD   32'h0000_0000  instruction inserted into IF/ID on flush/reset
// PORTS
//   clk              in   1   system clock, rising edge
//   reset            in   1   asynchronous, active-high
//   stall            in   1   hazard unit: hold PC and IF/ID (load-use)
//   branch_taken     in   1   EX stage: conditional branch resolved taken
//   branch_target    in   32  EX stage: branch destination byte address
//   jump             in   1   ID stage: j/jal/jr/jalr decoded
//   jump_target      in   32  ID stage: jump destination byte address
//   imem_instr       in   32  word returned combinationally by InstructionMemory
//   imem_addr        out  32  current PC, drives InstructionMemory Address
//   ifid_instr       out  32  IF/ID register: fetched instruction
//   ifid_pc_plus4    out  32  IF/ID register: PC+4 of that instruction (jal link)
//   ifid_valid       out  1   IF/ID register holds a real instruction
// BEHAVIOUR
//   Reset (async, any time, incl. mid-redirect): pc<=RESET_PC, ifid_instr<=NOP_WORD,
//     ifid_pc_plus4<=0, ifid_valid<=0. First rising edge after release latches
//     word at RESET_PC with ifid_valid=1.
//   imem_addr = pc (registered). pc[1:0] always 2'b00: targets are written
//     with bits[1:0] forced to zero. PC+4 is 32-bit modulo (0xFFFF_FFFC -> 0).
//   Next-PC priority per edge (highest first):
//     1 branch_taken          : pc<=branch_target; IF/ID<=bubble (flushes the
//                               wrong-path words in IF and ID; ID/EX flush is
//                               hazard-unit duty)
//     2 jump && !stall        : pc<=jump_target;   IF/ID<=bubble
//     3 stall                 : pc and IF/ID hold all values
//     4 otherwise             : pc<=pc+4; IF/ID<={imem_instr, pc+4, valid=1}
//   Bubble = {NOP_WORD, ifid_pc_plus4 unchanged, valid=0}.
//   branch_taken overrides stall (a stalled ID instruction behind a taken branch
//     is wrong-path). jump with stall=1 is ignored; the jump is re-presented
//     next cycle because ID is frozen.
//   branch_taken and jump in same cycle: branch wins (older instruction).
//   Latency: instruction at PC appears on ifid_instr one edge after pc==PC.
//     Taken branch/jump costs exactly one bubble in IF/ID.
//   No FSM beyond the PC/IF/ID registers; no handshake with memory (single-
//     cycle combinational ROM).
// STRUCTURE
//   Shared package (pipeline_defs): RESET_PC, NOP_WORD, PC width constant.
//   One sub-module: ifid_reg (IF/ID register with hold/flush inputs, async
//   reset), reused pattern for later stage registers. Next-PC mux and pc
//   register live in if_stage top.
// TESTING
//   T1 reset: assert reset mid-run -> imem_addr=0x0040_0000, ifid_valid=0,
//      ifid_instr=0 immediately; release -> next edge ifid_instr=0x24080000,
//      ifid_pc_plus4=0x0040_0004.
//   T2 sequential: 4 edges no stall -> imem_addr 0x0040_0004..0x0040_0010,
//      ifid_pc_plus4 tracks imem_addr.
//   T3 stall: stall=1 for 2 cycles at pc=0x0040_0008 -> pc and IF/ID hold
//      exactly; on release pc=0x0040_000C after one edge.
//   T4 jump: jump=1, jump_target=0x0040_0024 -> pc=0x0040_0024, ifid_valid=0;
//      next edge ifid_instr=word@0x24, valid=1. With stall=1: no change.
//   T5 branch vs jump vs stall: branch_taken=1 target=0x0040_0040, jump=1
//      target=0x0040_0100, stall=1 same cycle -> pc=0x0040_0040, bubble.
//   T6 alignment/wrap: jump_target=0x0040_0027 -> pc=0x0040_0024;
//      branch_target=0xFFFF_FFFC then one edge -> pc=0x0000_0000.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions: PC width, reset/NOP constants, IF/ID payload and
// next-PC source selection used by the fetch stage and later stage registers.
package pipeline_defs;

  localparam int unsigned PC_W = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0040_0000;
  localparam logic [31:0]     NOP_WORD_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_SEQ,
    PC_HOLD,
    PC_JUMP,
    PC_BRANCH
  } pc_sel_e;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc_plus4;
    logic            valid;
  } ifid_t;

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register with hold and flush controls and asynchronous reset.
// A flush leaves pc_plus4 untouched so only instr/valid mark the bubble.
module ifid_reg
  import pipeline_defs::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  hold_i,
  input  logic  flush_i,
  input  ifid_t d_i,
  output ifid_t q_o
);

  ifid_t q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q.instr    <= NOP_WORD;
      q_q.pc_plus4 <= '0;
      q_q.valid    <= 1'b0;
    end else if (flush_i) begin
      q_q.instr <= NOP_WORD;
      q_q.valid <= 1'b0;
    end else if (!hold_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection (branch > jump > stall
// > sequential) and the IF/ID register fed from the combinational instruction ROM.
module if_stage
  import pipeline_defs::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0]     NOP_WORD = NOP_WORD_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic [31:0]     imem_instr,
  output logic [PC_W-1:0] imem_addr,
  output logic [31:0]     ifid_instr,
  output logic [PC_W-1:0] ifid_pc_plus4,
  output logic            ifid_valid
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_plus4;
  pc_sel_e         pc_sel;
  ifid_t           ifid_d;
  ifid_t           ifid_q;

  assign pc_plus4 = pc_q + 32'd4;

  // A taken branch overrides stall: the stalled ID instruction is wrong-path.
  always_comb begin
    if (branch_taken)        pc_sel = PC_BRANCH;
    else if (jump && !stall) pc_sel = PC_JUMP;
    else if (stall)          pc_sel = PC_HOLD;
    else                     pc_sel = PC_SEQ;
  end

  always_comb begin
    pc_d = pc_plus4;
    case (pc_sel)
      PC_BRANCH: pc_d = word_align(branch_target);
      PC_JUMP:   pc_d = word_align(jump_target);
      PC_HOLD:   pc_d = pc_q;
      default:   pc_d = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  always_comb begin
    ifid_d.instr    = imem_instr;
    ifid_d.pc_plus4 = pc_plus4;
    ifid_d.valid    = 1'b1;
  end

  ifid_reg #(
    .NOP_WORD (NOP_WORD)
  ) u_ifid_reg (
    .clk     (clk),
    .rst     (reset),
    .hold_i  (pc_sel == PC_HOLD),
    .flush_i ((pc_sel == PC_BRANCH) || (pc_sel == PC_JUMP)),
    .d_i     (ifid_d),
    .q_o     (ifid_q)
  );

  assign imem_addr     = pc_q;
  assign ifid_instr    = ifid_q.instr;
  assign ifid_pc_plus4 = ifid_q.pc_plus4;
  assign ifid_valid    = ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized control
// traffic, all checked against a rule-level model of the fetch stage.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic [31:0] imem_instr;
  logic [31:0] imem_addr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;

  logic [96:0] obs;
  logic [96:0] exp_v;

  always #5 clk = ~clk;

  // ROM contents: word at RESET_PC is 0x24080000, every other address unique
  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h2408_0000 ^ (a - RST_PC);
  endfunction

  always_comb imem_instr = rom(imem_addr);
  assign obs   = {imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid};
  assign exp_v = {m_pc, m_instr, m_pc4, m_valid};

  if_stage #(
    .RESET_PC (32'h0040_0000),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_instr    (imem_instr),
    .imem_addr     (imem_addr),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_valid    (ifid_valid)
  );

  task automatic model_reset();
    m_pc = RST_PC; m_instr = NOP; m_pc4 = '0; m_valid = 1'b0;
  endtask

  // Advance the model by one edge using the current inputs, then wait for the
  // edge and settle 1 ns past it.
  task automatic tick();
    if (reset) begin
      model_reset();
    end else if (branch_taken) begin
      m_pc = branch_target & ~32'h3; m_instr = NOP; m_valid = 1'b0;
    end else if (jump && !stall) begin
      m_pc = jump_target & ~32'h3; m_instr = NOP; m_valid = 1'b0;
    end else if (!stall) begin
      m_instr = rom(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = '0; jump_target = '0;
  endtask

  task automatic restart();
    clear_inputs();
    #2 reset = 1'b1;
    model_reset();
    tick();
    #2 reset = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_checks++;
    if (obs !== {RST_PC, NOP, 32'h0, 1'b0})
      $display("FAIL reset_hold got=%h exp=%h", obs, {RST_PC, NOP, 32'h0, 1'b0});
    else n_pass++;
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (obs !== exp_v) $display("FAIL reset_run got=%h exp=%h", obs, exp_v);
    else n_pass++;
    // Assert reset in the middle of a redirect cycle; effect must be immediate
    branch_taken = 1'b1; branch_target = 32'h1234_5678;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (obs !== {RST_PC, NOP, 32'h0, 1'b0})
      $display("FAIL reset_async got=%h exp=%h", obs, {RST_PC, NOP, 32'h0, 1'b0});
    else n_pass++;
    model_reset();
    tick();
    clear_inputs();
    #2 reset = 1'b0;
    tick();
    n_checks++;
    if (ifid_instr !== 32'h2408_0000 || ifid_pc_plus4 !== 32'h0040_0004 || ifid_valid !== 1'b1)
      $display("FAIL reset_first_fetch got=%h/%h/%b exp=24080000/00400004/1",
               ifid_instr, ifid_pc_plus4, ifid_valid);
    else n_pass++;
  endtask

  task automatic test_sequential();
    restart();
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_checks++;
      if (imem_addr !== RST_PC + 32'(4 * k) || ifid_pc_plus4 !== RST_PC + 32'(4 * k) || obs !== exp_v)
        $display("FAIL seq_%0d got=%h exp=%h", k, obs, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    logic [96:0] snap;
    restart();
    tick(); tick();
    snap = obs;
    n_checks++;
    if (imem_addr !== 32'h0040_0008) $display("FAIL stall_setup got=%h exp=00400008", imem_addr);
    else n_pass++;
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (obs !== snap || obs !== exp_v) $display("FAIL stall_hold got=%h exp=%h", obs, exp_v);
      else n_pass++;
    end
    stall = 1'b0;
    tick();
    n_checks++;
    if (imem_addr !== 32'h0040_000C || ifid_instr !== rom(32'h0040_0008) || ifid_valid !== 1'b1)
      $display("FAIL stall_release got=%h exp=%h", obs, exp_v);
    else n_pass++;
  endtask

  task automatic test_jump();
    jump = 1'b1; jump_target = 32'h0040_0024;
    tick();
    n_checks++;
    if (imem_addr !== 32'h0040_0024 || ifid_valid !== 1'b0 || ifid_instr !== NOP || obs !== exp_v)
      $display("FAIL jump_redirect got=%h exp=%h", obs, exp_v);
    else n_pass++;
    jump = 1'b0;
    tick();
    n_checks++;
    if (ifid_instr !== rom(32'h0040_0024) || ifid_valid !== 1'b1 || imem_addr !== 32'h0040_0028)
      $display("FAIL jump_target_fetch got=%h exp=%h", obs, exp_v);
    else n_pass++;
    stall = 1'b1; jump = 1'b1; jump_target = 32'h0040_0100;
    tick();
    n_checks++;
    if (imem_addr !== 32'h0040_0028 || obs !== exp_v)
      $display("FAIL jump_stalled got=%h exp=%h", obs, exp_v);
    else n_pass++;
    stall = 1'b0;
    tick();
    n_checks++;
    if (imem_addr !== 32'h0040_0100 || ifid_valid !== 1'b0)
      $display("FAIL jump_represented got=%h exp=%h", obs, exp_v);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_priority();
    logic [31:0] pc4_before;
    tick(); tick();
    pc4_before = ifid_pc_plus4;
    branch_taken = 1'b1; branch_target = 32'h0040_0040;
    jump = 1'b1; jump_target = 32'h0040_0100; stall = 1'b1;
    tick();
    n_checks++;
    if (imem_addr !== 32'h0040_0040 || ifid_instr !== NOP || ifid_valid !== 1'b0 ||
        ifid_pc_plus4 !== pc4_before || obs !== exp_v)
      $display("FAIL prio_br_jmp_stall got=%h exp=%h", obs, exp_v);
    else n_pass++;
    stall = 1'b0; branch_target = 32'h0040_0080;
    tick();
    n_checks++;
    if (imem_addr !== 32'h0040_0080 || obs !== exp_v)
      $display("FAIL prio_br_jmp got=%h exp=%h", obs, exp_v);
    else n_pass++;
    clear_inputs();
    tick();
  endtask

  task automatic test_align_wrap();
    jump = 1'b1; jump_target = 32'h0040_0027;
    tick();
    n_checks++;
    if (imem_addr !== 32'h0040_0024) $display("FAIL align_jump got=%h exp=00400024", imem_addr);
    else n_pass++;
    jump = 1'b0; branch_taken = 1'b1; branch_target = 32'h0040_003B;
    tick();
    n_checks++;
    if (imem_addr !== 32'h0040_0038) $display("FAIL align_branch got=%h exp=00400038", imem_addr);
    else n_pass++;
    branch_target = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    tick();
    n_checks++;
    if (imem_addr !== 32'h0000_0000 || ifid_pc_plus4 !== 32'h0000_0000 ||
        ifid_instr !== rom(32'hFFFF_FFFC) || ifid_valid !== 1'b1)
      $display("FAIL wrap got=%h exp=%h", obs, exp_v);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      branch_taken  = ($urandom_range(7) == 0);
      jump          = ($urandom_range(4) == 0);
      stall         = ($urandom_range(3) == 0);
      branch_target = $urandom;
      jump_target   = $urandom;
      if ($urandom_range(63) == 0) begin
        #2 reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (obs !== exp_v) $display("FAIL rand_reset_%0d got=%h exp=%h", i, obs, exp_v);
        else n_pass++;
        tick();
        #2 reset = 1'b0;
      end
      tick();
      n_checks++;
      if (obs !== exp_v) $display("FAIL rand_%0d got=%h exp=%h", i, obs, exp_v);
      else n_pass++;
    end
    clear_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_stall();
    test_jump();
    test_priority();
    test_align_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

endmodule
